// File: rtl/ctrl_decode_stage.sv
// Registered RV32I main control decoder between IF/ID and ID/EX, with valid/ready, stall and flush.
// Define MULDIV_EN to decode M-extension ops and hold them MULDIV_CYCLES cycles in the HOLD state.
module ctrl_decode_stage #(
    parameter int unsigned MULDIV_CYCLES = 4,
    parameter int unsigned CNT_W         = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        stall,
    input  logic        flush,
    output logic        out_valid,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        ALUASrc,
    output logic        MemWrite,
    output logic        Branch,
    output logic        Jump,
    output logic        JumpReg,
    output logic [2:0]  ImmSrc,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUOp,
    output logic        MulDiv,
    output logic        illegal,
    output logic        busy
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam bit               HOLD_EN  = (MULDIV_CYCLES > 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic       illegal;
        logic       muldiv;
        logic       reg_write;
        logic       alu_src;
        logic       alua_src;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jump_reg;
        logic [2:0] imm_src;
        logic [1:0] result_src;
        logic [1:0] alu_op;
    } ctrl_t;

    logic [6:0]       w_op;
    logic [2:0]       w_f3;
    logic [6:0]       w_f7;
    logic             w_unused_instr;
    logic             w_accept;
    ctrl_t            w_dec;
    ctrl_t            w_ctrl_nxt;
    ctrl_t            r_ctrl;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_valid;
    logic             w_valid_nxt;

    assign w_op           = instr[6:0];
    assign w_f3           = instr[14:12];
    assign w_f7           = instr[31:25];
    assign w_unused_instr = ^{instr[24:15], instr[11:7]};

    assign in_ready = !stall && (r_state == S_IDLE);
    assign w_accept = in_valid && in_ready && !flush;

    // Opcode/funct decode; funct-level illegal encodings clear every control bit
    always_comb begin
        w_dec = '0;
        case (w_op)
            OP_LOAD: begin
                w_dec.reg_write  = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.result_src = 2'b01;
            end
            OP_STORE: begin
                w_dec.alu_src   = 1'b1;
                w_dec.mem_write = 1'b1;
                w_dec.imm_src   = 3'b001;
            end
            OP_R: begin
                if (w_f7 == 7'b0000000 || w_f7 == 7'b0100000) begin
                    w_dec.reg_write = 1'b1;
                    w_dec.alu_op    = 2'b10;
`ifdef MULDIV_EN
                end else if (w_f7 == 7'b0000001) begin
                    w_dec.reg_write = 1'b1;
                    w_dec.muldiv    = 1'b1;
                    w_dec.alu_op    = 2'b10;
`endif
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            OP_IALU: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.imm_src   = 3'b100;
                w_dec.alu_op    = 2'b11;
            end
            OP_BR: begin
                if (w_f3 == 3'b010 || w_f3 == 3'b011) begin
                    w_dec.illegal = 1'b1;
                end else begin
                    w_dec.branch  = 1'b1;
                    w_dec.imm_src = 3'b010;
                    w_dec.alu_op  = 2'b01;
                end
            end
            OP_JAL: begin
                w_dec.reg_write  = 1'b1;
                w_dec.jump       = 1'b1;
                w_dec.imm_src    = 3'b011;
                w_dec.result_src = 2'b10;
            end
            OP_JALR: begin
                if (w_f3 != 3'b000) begin
                    w_dec.illegal = 1'b1;
                end else begin
                    w_dec.reg_write  = 1'b1;
                    w_dec.jump       = 1'b1;
                    w_dec.jump_reg   = 1'b1;
                    w_dec.alu_src    = 1'b1;
                    w_dec.result_src = 2'b10;
                end
            end
            OP_LUI: begin
                w_dec.reg_write  = 1'b1;
                w_dec.imm_src    = 3'b101;
                w_dec.result_src = 2'b11;
            end
            OP_AUIPC: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.alua_src  = 1'b1;
                w_dec.imm_src   = 3'b101;
            end
            default: begin
                w_dec.illegal = 1'b1;
                w_dec.imm_src = 3'b101;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_ctrl  <= w_ctrl_nxt;
        end
    end

    // Next state: flush beats stall; stall freezes everything; HOLD releases the op as the count expires
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        w_ctrl_nxt  = r_ctrl;
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_valid_nxt = 1'b0;
        end else if (!stall) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_ctrl_nxt = w_dec;
                        if (w_dec.muldiv && HOLD_EN) begin
                            w_state_nxt = S_HOLD;
                            w_cnt_nxt   = CNT_LOAD;
                            w_valid_nxt = 1'b0;
                        end else begin
                            w_valid_nxt = 1'b1;
                        end
                    end else begin
                        w_valid_nxt = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (r_cnt <= CNT_W'(1)) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign out_valid = r_valid;
    assign RegWrite  = r_ctrl.reg_write;
    assign ALUSrc    = r_ctrl.alu_src;
    assign ALUASrc   = r_ctrl.alua_src;
    assign MemWrite  = r_ctrl.mem_write;
    assign Branch    = r_ctrl.branch;
    assign Jump      = r_ctrl.jump;
    assign JumpReg   = r_ctrl.jump_reg;
    assign ImmSrc    = r_ctrl.imm_src;
    assign ResultSrc = r_ctrl.result_src;
    assign ALUOp     = r_ctrl.alu_op;
    assign illegal   = r_ctrl.illegal;
`ifdef MULDIV_EN
    assign MulDiv    = r_ctrl.muldiv;
    assign busy      = (r_state == S_HOLD);
`else
    assign MulDiv    = 1'b0;
    assign busy      = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Self-checking bench for ctrl_decode_stage: directed cases plus randomized traffic against a
// cycle-level reference model. Honours MULDIV_EN the same way as the design.
module tb_ctrl_decode_stage;

    localparam int unsigned CYC = 4;
    localparam int unsigned CW  = 3;
`ifdef MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, stall, flush;
    logic [31:0] instr;
    logic        out_valid, RegWrite, ALUSrc, ALUASrc, MemWrite, Branch, Jump, JumpReg;
    logic [2:0]  ImmSrc;
    logic [1:0]  ResultSrc, ALUOp;
    logic        MulDiv, illegal, busy;

    always #5 clk = ~clk;

    ctrl_decode_stage #(.MULDIV_CYCLES(CYC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .stall(stall), .flush(flush), .out_valid(out_valid), .RegWrite(RegWrite),
        .ALUSrc(ALUSrc), .ALUASrc(ALUASrc), .MemWrite(MemWrite), .Branch(Branch),
        .Jump(Jump), .JumpReg(JumpReg), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc),
        .ALUOp(ALUOp), .MulDiv(MulDiv), .illegal(illegal), .busy(busy)
    );

    typedef struct packed {
        logic       ill, md, rw, asrc, aasrc, mw, br, jmp, jr;
        logic [2:0] imm;
        logic [1:0] res, aop;
    } bundle_t;

    bundle_t dut_b;
    assign dut_b = {illegal, MulDiv, RegWrite, ALUSrc, ALUASrc, MemWrite, Branch, Jump,
                    JumpReg, ImmSrc, ResultSrc, ALUOp};

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference decode straight from the instruction table
    function automatic bundle_t ref_decode(input logic [31:0] ins);
        bundle_t    b;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        b  = '0;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (op)
            7'h03: begin b.rw = 1; b.asrc = 1; b.res = 2'b01; end
            7'h23: begin b.asrc = 1; b.mw = 1; b.imm = 3'b001; end
            7'h33: begin
                if (f7 == 7'h00 || f7 == 7'h20) begin b.rw = 1; b.aop = 2'b10; end
                else if (f7 == 7'h01 && MD) begin b.rw = 1; b.md = 1; b.aop = 2'b10; end
                else b.ill = 1;
            end
            7'h13: begin b.rw = 1; b.asrc = 1; b.imm = 3'b100; b.aop = 2'b11; end
            7'h63: begin
                if (f3 == 3'd2 || f3 == 3'd3) b.ill = 1;
                else begin b.br = 1; b.imm = 3'b010; b.aop = 2'b01; end
            end
            7'h6F: begin b.rw = 1; b.jmp = 1; b.imm = 3'b011; b.res = 2'b10; end
            7'h67: begin
                if (f3 != 3'd0) b.ill = 1;
                else begin b.rw = 1; b.jmp = 1; b.jr = 1; b.asrc = 1; b.res = 2'b10; end
            end
            7'h37: begin b.rw = 1; b.imm = 3'b101; b.res = 2'b11; end
            7'h17: begin b.rw = 1; b.asrc = 1; b.aasrc = 1; b.imm = 3'b101; end
            default: begin b.ill = 1; b.imm = 3'b101; end
        endcase
        return b;
    endfunction

    // Model: m_hold counts cycles still owed before a held op is presented
    logic    m_valid;
    int      m_hold;
    bundle_t m_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 1'b0;
            m_hold  = 0;
            m_b     = '0;
        end else if (flush) begin
            m_valid = 1'b0;
            m_hold  = 0;
        end else if (!stall) begin
            if (m_hold > 0) begin
                m_hold = m_hold - 1;
                if (m_hold == 0) m_valid = 1'b1;
            end else if (in_valid) begin
                m_b = ref_decode(instr);
                if (m_b.md && CYC > 1) begin
                    m_hold  = CYC - 1;
                    m_valid = 1'b0;
                end else begin
                    m_valid = 1'b1;
                end
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("busy", 32'(busy), 32'(m_hold > 0));
            check("in_ready", 32'(in_ready), 32'(!stall && m_hold == 0));
            check("bundle", 32'(dut_b), 32'(m_b));
        end
    end

    task automatic step(input logic v, input logic [31:0] ins, input logic s, input logic f);
        in_valid = v;
        instr    = ins;
        stall    = s;
        flush    = f;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10];
        logic [31:0] w;
        int          k;
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
        w   = $urandom;
        k   = $urandom_range(0, 10);
        if (k < 10) w[6:0] = ops[k];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        rst = 1'b0; in_valid = 1'b0; instr = '0; stall = 1'b0; flush = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst bundle", 32'(dut_b), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk_en = 1'b1;

        // LW then SW back to back
        step(1, 32'h00A12083, 0, 0);
        check("lw valid", 32'(out_valid), 32'd1);
        check("lw RegWrite", 32'(RegWrite), 32'd1);
        check("lw ALUSrc", 32'(ALUSrc), 32'd1);
        check("lw ResultSrc", 32'(ResultSrc), 32'b01);
        step(1, 32'h00112423, 0, 0);
        check("sw MemWrite", 32'(MemWrite), 32'd1);
        check("sw ImmSrc", 32'(ImmSrc), 32'b001);
        check("sw RegWrite", 32'(RegWrite), 32'd0);

        // LUI held under stall while a new instr waits
        step(1, 32'h123450B7, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h00112423, 1, 0);
            check("stall valid", 32'(out_valid), 32'd1);
            check("stall ResultSrc", 32'(ResultSrc), 32'b11);
            check("stall ImmSrc", 32'(ImmSrc), 32'b101);
            check("stall in_ready", 32'(in_ready), 32'd0);
        end
        step(0, 32'h0, 0, 0);
        check("bubble valid", 32'(out_valid), 32'd0);
        check("bubble keeps ResultSrc", 32'(ResultSrc), 32'b11);

        // Flush drops the same-cycle JAL, with and without stall
        step(1, 32'h008000EF, 0, 1);
        check("flush valid", 32'(out_valid), 32'd0);
        check("flush Jump", 32'(Jump), 32'd0);
        step(1, 32'h123450B7, 0, 0);
        step(1, 32'h008000EF, 1, 1);
        check("flush+stall valid", 32'(out_valid), 32'd0);

        // Illegal opcode and illegal JALR funct3
        step(1, 32'h0000007F, 0, 0);
        check("bad op illegal", 32'(illegal), 32'd1);
        check("bad op RegWrite", 32'(RegWrite), 32'd0);
        check("bad op ImmSrc", 32'(ImmSrc), 32'b101);
        step(1, 32'h00002067, 0, 0);
        check("jalr f3 illegal", 32'(illegal), 32'd1);
        check("jalr f3 Jump", 32'(Jump), 32'd0);
        check("jalr f3 MemWrite", 32'(MemWrite), 32'd0);

        // MUL
        step(1, 32'h022081B3, 0, 0);
`ifdef MULDIV_EN
        check("mul busy 1", 32'(busy), 32'd1);
        check("mul hidden 1", 32'(out_valid), 32'd0);
        for (int i = 2; i <= 3; i++) begin
            step(0, 32'h0, 0, 0);
            check("mul busy", 32'(busy), 32'd1);
            check("mul hidden", 32'(out_valid), 32'd0);
        end
        step(0, 32'h0, 0, 0);
        check("mul valid", 32'(out_valid), 32'd1);
        check("mul MulDiv", 32'(MulDiv), 32'd1);
        check("mul busy done", 32'(busy), 32'd0);
`else
        check("mul illegal", 32'(illegal), 32'd1);
        check("mul valid", 32'(out_valid), 32'd1);
        check("mul busy", 32'(busy), 32'd0);
`endif

        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 3) != 0), rand_instr(),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset away from any clock edge, mid-operation
        step(1, 32'h022081B3, 0, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst bundle", 32'(dut_b), 32'd0);
        check("async rst in_ready", 32'(in_ready), 32'd1);
        check("async rst busy", 32'(busy), 32'd0);
        #1 rst = 1'b0;
        @(posedge clk);
        #2;
        step(1, 32'h00A12083, 0, 0);
        check("post rst lw", 32'(RegWrite), 32'd1);
        step(0, 32'h0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
